// File: rtl/fivecpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// fivecpu_mem_pkg
// Shared constants for the memory-side blocks of the fivecpu core: the
// refill FSM state encoding and the AXI4 field values used on the read
// channel.
// Ports: none (package).
// ---------------------------------------------------------------------------
package fivecpu_mem_pkg;

    // Refill FSM encoding. The bare localparams are the legacy-compatible
    // view. The enum exists for code and waveforms that want symbolic names.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } refill_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/inst_refill_responder.sv
// ---------------------------------------------------------------------------
// inst_refill_responder
// Memory-side responder for i$ line refills. It accepts one line request and
// issues one AXI4 INCR read burst of LINE_WORDS beats. Each returned beat is
// forwarded to the i$ exactly one cycle later, in order. Only one refill is
// outstanding at a time.
//
// Optional feature macro: INST_REFILL_RRESP_ERR_EN
//   When defined, the output inst_read_err flags a non-OKAY rresp. The flag is
//   aligned with mmu_valid for that word. When undefined, the port is absent
//   and rresp is ignored.
//
// Handshakes:
//   i$ side : inst_read_req is a level held until inst_addr_ok. inst_addr_ok
//             is combinational and only asserts in IDLE. mmu_valid marks one
//             word per cycle. mmu_last marks the final word. There is no
//             backpressure.
//   AXI side: standard valid/ready. A transfer happens on a cycle with
//             valid && ready. AR fields stay stable while arvalid is high.
//             rready is held high for the whole data phase.
//
// Ports:
//   clk, rst            clock / async active-low reset
//   inst_addr_mmu       line address from the i$
//   inst_read_req       refill request
//   inst_addr_ok        request accepted this cycle
//   inst_read_data      returned word (registered)
//   mmu_valid/mmu_last  word valid / final word of the line
//   ar*                 AXI read-address channel
//   r*                  AXI read-data channel
//   inst_read_err       (macro only) non-OKAY response for this word
//   dbg_state           current FSM state, for observation
// ---------------------------------------------------------------------------
module inst_refill_responder
    import fivecpu_mem_pkg::*;
#(
    parameter int LINE_WORDS = 16,
    parameter int AXI_ID     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_mmu,
    input  logic        inst_read_req,
    output logic        inst_addr_ok,
    output logic [31:0] inst_read_data,
    output logic        mmu_valid,
    output logic        mmu_last,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
`ifdef INST_REFILL_RRESP_ERR_EN
    output logic        inst_read_err,
`endif
    output logic [1:0]  dbg_state
);

    localparam int OFF_BITS = $clog2(LINE_WORDS * 4);
    localparam int CNT_W    = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [31:0]      araddr_q;
    logic             beat;
    logic             last_beat;

    // The beat count alone decides where the line ends. rlast is
    // deliberately unused, so an early or late rlast cannot cut the line
    // short or stretch it.
    assign beat      = (state == ST_DATA) && rvalid;
    assign last_beat = beat && (beat_cnt == LAST_BEAT);

    // Gating with rst keeps the accept low while reset is held, even though
    // the state already reads IDLE at that time.
    assign inst_addr_ok = rst && (state == ST_IDLE) && inst_read_req;

    assign arvalid   = (state == ST_ADDR);
    assign rready    = (state == ST_DATA);
    assign araddr    = araddr_q;
    assign arid      = 4'(AXI_ID);
    assign arlen     = 8'(LINE_WORDS - 1);
    assign arsize    = AXI_SIZE_4B;
    assign arburst   = AXI_BURST_INCR;
    assign dbg_state = state;

    // Control FSM and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            araddr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inst_read_req) begin
                        // Force line alignment even if the i$ hands over
                        // stray offset bits.
                        araddr_q <= {inst_addr_mmu[31:OFF_BITS], {OFF_BITS{1'b0}}};
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arready) begin
                        state    <= ST_DATA;
                        beat_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (rvalid) begin
                        // The counter wraps back to 0 on the last beat.
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Word output register. It adds exactly one cycle of latency, and gaps
    // in rvalid appear as gaps in mmu_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mmu_valid      <= 1'b0;
            mmu_last       <= 1'b0;
            inst_read_data <= '0;
        end else begin
            mmu_valid <= beat;
            mmu_last  <= last_beat;
            if (beat) begin
                inst_read_data <= rdata;
            end
        end
    end

`ifdef INST_REFILL_RRESP_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_read_err <= 1'b0;
        end else begin
            inst_read_err <= beat && (rresp != AXI_RESP_OKAY);
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{rlast, inst_addr_mmu[OFF_BITS-1:0]};
`else
    logic unused_inputs;
    assign unused_inputs = ^{rlast, rresp, inst_addr_mmu[OFF_BITS-1:0]};
`endif

endmodule

// File: tb/tb_inst_refill_responder.sv
// ---------------------------------------------------------------------------
// tb_inst_refill_responder
// Directed bench for inst_refill_responder with LINE_WORDS=16. Each line is
// driven cycle by cycle. Inputs change 1 ns after the rising edge. Outputs
// are checked 1 ns after the edge, once the registers have settled.
// ---------------------------------------------------------------------------
module tb_inst_refill_responder;

    localparam int LINE_WORDS = 16;
    localparam logic [31:0] LINE_MASK = ~32'(LINE_WORDS * 4 - 1);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr_mmu;
    logic        inst_read_req;
    logic        inst_addr_ok;
    logic [31:0] inst_read_data;
    logic        mmu_valid;
    logic        mmu_last;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
`ifdef INST_REFILL_RRESP_ERR_EN
    logic        inst_read_err;
`endif
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    inst_refill_responder #(.LINE_WORDS(LINE_WORDS), .AXI_ID(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr_mmu  (inst_addr_mmu),
        .inst_read_req  (inst_read_req),
        .inst_addr_ok   (inst_addr_ok),
        .inst_read_data (inst_read_data),
        .mmu_valid      (mmu_valid),
        .mmu_last       (mmu_last),
        .arid           (arid),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arburst        (arburst),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready),
`ifdef INST_REFILL_RRESP_ERR_EN
        .inst_read_err  (inst_read_err),
`endif
        .dbg_state      (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] addr, input int b);
        return {addr[15:0], 8'hA5, 8'(b)};
    endfunction

    // Runs one line request. ar_delay is the number of cycles arready stays
    // low. gap is the number of idle cycles between beats. A value of -1 in
    // rlast_beat, err_beat or rst_beat disables that feature.
    task automatic do_line(input logic [31:0] addr, input int ar_delay, input int gap,
                           input int rlast_beat, input int err_beat, input int rst_beat);
        logic [31:0] exp_addr;
        exp_addr = addr & LINE_MASK;

        // request phase
        inst_addr_mmu = addr;
        inst_read_req = 1'b1;
        #1;
        chk("addr_ok_idle", inst_addr_ok, 1);
        chk("state_idle", dbg_state, 0);
        @(posedge clk); #1;
        inst_read_req = 1'b0;
        inst_addr_mmu = 32'hDEAD_BEEF;

        // address phase
        for (int i = 0; i <= ar_delay; i++) begin
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, exp_addr);
            chk("addr_ok_busy", inst_addr_ok, 0);
            chk("state_addr", dbg_state, 1);
            if (i == 0) begin
                chk("arlen", arlen, 15);
                chk("arsize", arsize, 3'b010);
                chk("arburst", arburst, 2'b01);
                chk("arid", arid, 0);
            end
            arready = (i == ar_delay);
            @(posedge clk); #1;
            arready = 1'b0;
        end
        chk("arvalid_drop", arvalid, 0);
        chk("rready", rready, 1);
        chk("state_data", dbg_state, 2);

        // data phase
        for (int b = 0; b < LINE_WORDS; b++) begin
            if (b == rst_beat) begin
                rvalid = 1'b0;
                rst    = 1'b0;
                #1;
                chk("rst_valid", mmu_valid, 0);
                chk("rst_last", mmu_last, 0);
                chk("rst_data", inst_read_data, 0);
                chk("rst_rready", rready, 0);
                chk("rst_state", dbg_state, 0);
                @(posedge clk); #1;
                chk("rst_hold_valid", mmu_valid, 0);
                rst = 1'b1;
                return;
            end
            rvalid = 1'b1;
            rdata  = word_of(addr, b);
            rlast  = (b == rlast_beat);
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            @(posedge clk); #1;
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            rdata  = 32'h0BAD_0BAD;
            chk("mmu_valid", mmu_valid, 1);
            chk("word", inst_read_data, word_of(addr, b));
            chk("mmu_last", mmu_last, (b == LINE_WORDS - 1) ? 1 : 0);
`ifdef INST_REFILL_RRESP_ERR_EN
            chk("read_err", inst_read_err, (b == err_beat) ? 1 : 0);
`endif
            if (b < LINE_WORDS - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    chk("gap_valid", mmu_valid, 0);
                end
            end
        end
        chk("end_state", dbg_state, 0);
        chk("end_rready", rready, 0);
        @(posedge clk); #1;
        chk("after_valid", mmu_valid, 0);
        chk("after_last", mmu_last, 0);
    endtask

    initial begin
        rst           = 1'b0;
        inst_addr_mmu = '0;
        inst_read_req = 1'b1;
        arready       = 1'b0;
        rdata         = '0;
        rresp         = 2'b00;
        rlast         = 1'b0;
        rvalid        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr_ok", inst_addr_ok, 0);
        chk("reset_valid", mmu_valid, 0);
        chk("reset_last", mmu_last, 0);
        chk("reset_data", inst_read_data, 0);
        chk("reset_arvalid", arvalid, 0);
        chk("reset_rready", rready, 0);
        chk("reset_state", dbg_state, 0);
        inst_read_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        do_line(32'h0000_1040, 0, 0, -1, -1, -1);   // back-to-back beats
        do_line(32'h0000_2000, 5, 0, 15, -1, -1);   // slow arready
        do_line(32'h0000_3080, 1, 2, 15, -1, -1);   // gaps between beats
        do_line(32'h0000_4000, 0, 0, -1, -1, 7);    // reset at beat 7
        do_line(32'h0000_40C0, 0, 0, 15, -1, -1);   // fresh line after reset
        do_line(32'h0000_5000, 0, 0, 14, -1, -1);   // early rlast ignored
        do_line(32'h0000_6000, 0, 1, 15, 3, -1);    // error response on word 3
        do_line(32'h0000_2A7C, 2, 0, 15, -1, -1);   // unaligned address masked

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
